// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction-fetch / load-store memory arbiter.
package mem_arbiter_pkg;

    // Arbiter sequencing: pick a requester, present it to memctrl, wait for completion.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    // Which requester owns the outstanding transaction.
    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // funct3 width codes as carried on lsb_width / mc_width.
    localparam logic [2:0] W_B  = 3'b000;
    localparam logic [2:0] W_H  = 3'b001;
    localparam logic [2:0] W_W  = 3'b010;
    localparam logic [2:0] W_BU = 3'b100;
    localparam logic [2:0] W_HU = 3'b101;

    // Consecutive lost arbitrations tolerated by a pending fetch, and the counter width.
    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W_DEF      = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, LSB and memctrl handshake signals seen by the arbiter.
// slave: the arbiter's view. master: the surrounding requesters and memctrl.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_grant;
    logic        ic_done;
    logic [31:0] ic_data;

    logic        lsb_req;
    logic        lsb_wr;
    logic [2:0]  lsb_width;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_grant;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    logic        mc_valid;
    logic        mc_wr;
    logic [2:0]  mc_width;
    logic [31:0] mc_addr;
    logic [31:0] mc_wdata;
    logic        mc_accept;
    logic        mc_done;
    logic [31:0] mc_rdata;

    modport slave (
        input  ic_req, ic_addr,
        input  lsb_req, lsb_wr, lsb_width, lsb_addr, lsb_wdata,
        input  mc_accept, mc_done, mc_rdata,
        output ic_grant, ic_done, ic_data,
        output lsb_grant, lsb_done, lsb_rdata,
        output mc_valid, mc_wr, mc_width, mc_addr, mc_wdata
    );

    modport master (
        output ic_req, ic_addr,
        output lsb_req, lsb_wr, lsb_width, lsb_addr, lsb_wdata,
        output mc_accept, mc_done, mc_rdata,
        input  ic_grant, ic_done, ic_data,
        input  lsb_grant, lsb_done, lsb_rdata,
        input  mc_valid, mc_wr, mc_width, mc_addr, mc_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational priority pick between icache and LSB, plus the next starvation count.
// Stores always win; a fetch that has lost STARVE_MAX times in a row beats a load.
// A flush masks speculative loads and fetches but never a committed store.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             ic_req,
    input  logic             lsb_req,
    input  logic             lsb_wr,
    input  logic             clear_all,
    input  logic [CNT_W-1:0] starve,
    output logic             pick_ic,
    output logic             pick_ls,
    output logic [CNT_W-1:0] starve_next
);

    logic want_st;
    logic want_ld;
    logic want_ic;
    logic starved;

    // Priority decision and saturating loss counter for the pending fetch.
    always_comb begin
        want_st     = lsb_req & lsb_wr;
        want_ld     = lsb_req & ~lsb_wr & ~clear_all;
        want_ic     = ic_req & ~clear_all;
        starved     = (starve == CNT_W'(STARVE_MAX));
        pick_ic     = 1'b0;
        pick_ls     = 1'b0;
        starve_next = starve;

        if (want_st) begin
            pick_ls = 1'b1;
        end else if (want_ld && want_ic && starved) begin
            pick_ic = 1'b1;
        end else if (want_ld) begin
            pick_ls = 1'b1;
        end else if (want_ic) begin
            pick_ic = 1'b1;
        end

        if (pick_ic) begin
            starve_next = '0;
        end else if (want_ic && pick_ls && !starved) begin
            starve_next = starve + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter placing icache fetches and LSB loads/stores onto memctrl.
// All outputs are registered; rdy_in low freezes every register, outputs included.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          clear_all,
    mem_arbiter_if.slave  bus
);

    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    logic             kill_q, kill_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic             ic_grant_q, ic_grant_d;
    logic             ic_done_q, ic_done_d;
    logic [31:0]      ic_data_q, ic_data_d;
    logic             lsb_grant_q, lsb_grant_d;
    logic             lsb_done_q, lsb_done_d;
    logic [31:0]      lsb_rdata_q, lsb_rdata_d;
    logic             mc_valid_q, mc_valid_d;
    logic             mc_wr_q, mc_wr_d;
    logic [2:0]       mc_width_q, mc_width_d;
    logic [31:0]      mc_addr_q, mc_addr_d;
    logic [31:0]      mc_wdata_q, mc_wdata_d;

    logic             pick_ic;
    logic             pick_ls;
    logic [CNT_W-1:0] starve_next;
    logic             flush_hit;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .ic_req      (bus.ic_req),
        .lsb_req     (bus.lsb_req),
        .lsb_wr      (bus.lsb_wr),
        .clear_all   (clear_all),
        .starve      (starve_q),
        .pick_ic     (pick_ic),
        .pick_ls     (pick_ls),
        .starve_next (starve_next)
    );

    // Flush only affects the outstanding access when it is a fetch or a load.
    assign flush_hit = clear_all & ~mc_wr_q;

    // Next-state and next-output computation; pulses default low, everything else holds.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        kill_d      = kill_q;
        starve_d    = starve_q;
        ic_grant_d  = 1'b0;
        ic_done_d   = 1'b0;
        ic_data_d   = ic_data_q;
        lsb_grant_d = 1'b0;
        lsb_done_d  = 1'b0;
        lsb_rdata_d = lsb_rdata_q;
        mc_valid_d  = mc_valid_q;
        mc_wr_d     = mc_wr_q;
        mc_width_d  = mc_width_q;
        mc_addr_d   = mc_addr_q;
        mc_wdata_d  = mc_wdata_q;

        case (state_q)
            ARB_IDLE: begin
                kill_d   = 1'b0;
                starve_d = starve_next;
                if (pick_ic) begin
                    owner_d    = OWN_IC;
                    ic_grant_d = 1'b1;
                    mc_valid_d = 1'b1;
                    mc_wr_d    = 1'b0;
                    mc_width_d = W_W;
                    mc_addr_d  = bus.ic_addr;
                    mc_wdata_d = '0;
                    state_d    = ARB_ISSUE;
                end else if (pick_ls) begin
                    owner_d     = OWN_LS;
                    lsb_grant_d = 1'b1;
                    mc_valid_d  = 1'b1;
                    mc_wr_d     = bus.lsb_wr;
                    mc_width_d  = bus.lsb_width;
                    mc_addr_d   = bus.lsb_addr;
                    mc_wdata_d  = bus.lsb_wdata;
                    state_d     = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                // A flush arriving with the accept is too late to withdraw; kill instead.
                if (bus.mc_accept) begin
                    mc_valid_d = 1'b0;
                    kill_d     = flush_hit;
                    state_d    = ARB_WAIT;
                end else if (flush_hit) begin
                    mc_valid_d = 1'b0;
                    state_d    = ARB_IDLE;
                end
            end
            ARB_WAIT: begin
                if (bus.mc_done) begin
                    state_d = ARB_IDLE;
                    kill_d  = 1'b0;
                    if (!(kill_q || flush_hit)) begin
                        if (owner_q == OWN_IC) begin
                            ic_done_d = 1'b1;
                            ic_data_d = bus.mc_rdata;
                        end else begin
                            lsb_done_d  = 1'b1;
                            lsb_rdata_d = bus.mc_rdata;
                        end
                    end
                end else if (flush_hit) begin
                    kill_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access without a done pulse.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IC;
            kill_q      <= 1'b0;
            starve_q    <= '0;
            ic_grant_q  <= 1'b0;
            ic_done_q   <= 1'b0;
            ic_data_q   <= '0;
            lsb_grant_q <= 1'b0;
            lsb_done_q  <= 1'b0;
            lsb_rdata_q <= '0;
            mc_valid_q  <= 1'b0;
            mc_wr_q     <= 1'b0;
            mc_width_q  <= '0;
            mc_addr_q   <= '0;
            mc_wdata_q  <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            kill_q      <= kill_d;
            starve_q    <= starve_d;
            ic_grant_q  <= ic_grant_d;
            ic_done_q   <= ic_done_d;
            ic_data_q   <= ic_data_d;
            lsb_grant_q <= lsb_grant_d;
            lsb_done_q  <= lsb_done_d;
            lsb_rdata_q <= lsb_rdata_d;
            mc_valid_q  <= mc_valid_d;
            mc_wr_q     <= mc_wr_d;
            mc_width_q  <= mc_width_d;
            mc_addr_q   <= mc_addr_d;
            mc_wdata_q  <= mc_wdata_d;
        end
    end

    assign bus.ic_grant  = ic_grant_q;
    assign bus.ic_done   = ic_done_q;
    assign bus.ic_data   = ic_data_q;
    assign bus.lsb_grant = lsb_grant_q;
    assign bus.lsb_done  = lsb_done_q;
    assign bus.lsb_rdata = lsb_rdata_q;
    assign bus.mc_valid  = mc_valid_q;
    assign bus.mc_wr     = mc_wr_q;
    assign bus.mc_width  = mc_width_q;
    assign bus.mc_addr   = mc_addr_q;
    assign bus.mc_wdata  = mc_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_arbiter;

    localparam int STARVE = 4;

    logic clk;
    logic rst_n;
    logic rdy;
    logic clr;
    int   n_cmp;
    int   n_bad;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(STARVE), .CNT_W(3)) dut (
        .clk_in    (clk),
        .rst_in    (rst_n),
        .rdy_in    (rdy),
        .clear_all (clr),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ic_grant, lsb_grant, ic_done, lsb_done, mc_valid, mc_wr, mc_width}
    function automatic logic [8:0] ctl();
        return {bus.ic_grant, bus.lsb_grant, bus.ic_done, bus.lsb_done,
                bus.mc_valid, bus.mc_wr, bus.mc_width};
    endfunction

    task automatic idle_inputs();
        bus.ic_req = 0; bus.ic_addr = 0;
        bus.lsb_req = 0; bus.lsb_wr = 0; bus.lsb_width = 0; bus.lsb_addr = 0; bus.lsb_wdata = 0;
        bus.mc_accept = 0; bus.mc_done = 0; bus.mc_rdata = 0;
        clr = 0; rdy = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    // Plays memctrl from the cycle the grant is visible through the cycle done is visible.
    task automatic mc_serve(input int acc, input int dly, input logic [31:0] rd);
        repeat (acc) @(negedge clk);
        bus.mc_accept = 1;
        @(negedge clk);
        bus.mc_accept = 0;
        repeat (dly) @(negedge clk);
        bus.mc_done = 1; bus.mc_rdata = rd;
        @(negedge clk);
        bus.mc_done = 0;
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        do_reset();
        exp = '0;
        n_cmp++;
        if (ctl() !== exp) begin
            n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl(), exp);
        end
        n_cmp++;
        if ({bus.ic_data, bus.lsb_rdata, bus.mc_addr, bus.mc_wdata} !== 128'd0) begin
            n_bad++; $display("FAIL reset_data: got %h want 0",
                              {bus.ic_data, bus.lsb_rdata, bus.mc_addr, bus.mc_wdata});
        end
    endtask

    task automatic test_lone_fetch();
        do_reset();
        bus.ic_req = 1; bus.ic_addr = 32'h100;
        @(negedge clk);
        n_cmp++;
        if ({ctl(), bus.mc_addr} !== {9'b10_00_1_0_010, 32'h100}) begin
            n_bad++; $display("FAIL fetch_grant: got %b/%h want 100010010/00000100", ctl(), bus.mc_addr);
        end
        bus.ic_req = 0;
        bus.mc_accept = 1;
        @(negedge clk);
        bus.mc_accept = 0;
        n_cmp++;
        if (ctl() !== 9'b00_00_0_0_010) begin
            n_bad++; $display("FAIL fetch_accepted: got %b want 000000010", ctl());
        end
        repeat (3) @(negedge clk);
        bus.mc_done = 1; bus.mc_rdata = 32'h0000_0513;
        @(negedge clk);
        bus.mc_done = 0;
        n_cmp++;
        if ({bus.ic_done, bus.lsb_done, bus.ic_data} !== {2'b10, 32'h0000_0513}) begin
            n_bad++; $display("FAIL fetch_done: got %b%b/%h want 10/00000513",
                              bus.ic_done, bus.lsb_done, bus.ic_data);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.ic_done, bus.ic_data} !== {1'b0, 32'h0000_0513}) begin
            n_bad++; $display("FAIL fetch_data_hold: got %b/%h want 0/00000513", bus.ic_done, bus.ic_data);
        end
    endtask

    task automatic test_store_priority();
        do_reset();
        // Flush in the same cycle: the committed store must still be taken.
        clr = 1;
        bus.ic_req = 1; bus.ic_addr = 32'h200;
        bus.lsb_req = 1; bus.lsb_wr = 1; bus.lsb_width = 3'b000;
        bus.lsb_addr = 32'h0003_0000; bus.lsb_wdata = 32'h41;
        @(negedge clk);
        clr = 0;
        n_cmp++;
        if ({ctl(), bus.mc_addr, bus.mc_wdata} !== {9'b01_00_1_1_000, 32'h0003_0000, 32'h41}) begin
            n_bad++; $display("FAIL store_grant: got %b/%h/%h want 010011000/00030000/00000041",
                              ctl(), bus.mc_addr, bus.mc_wdata);
        end
        bus.lsb_req = 0; bus.lsb_wr = 0;
        mc_serve(1, 2, 32'h0);
        n_cmp++;
        if ({bus.ic_grant, bus.lsb_grant, bus.ic_done, bus.lsb_done} !== 4'b0001) begin
            n_bad++; $display("FAIL store_done: got %b want 0001",
                              {bus.ic_grant, bus.lsb_grant, bus.ic_done, bus.lsb_done});
        end
        @(negedge clk);
        n_cmp++;
        if ({ctl(), bus.mc_addr} !== {9'b10_00_1_0_010, 32'h200}) begin
            n_bad++; $display("FAIL store_then_fetch: got %b/%h want 100010010/00000200", ctl(), bus.mc_addr);
        end
        bus.ic_req = 0;
        mc_serve(0, 0, 32'hCAFE_0001);
        n_cmp++;
        if ({bus.ic_done, bus.ic_data} !== {1'b1, 32'hCAFE_0001}) begin
            n_bad++; $display("FAIL store_then_fetch_done: got %b/%h want 1/cafe0001", bus.ic_done, bus.ic_data);
        end
    endtask

    task automatic test_starvation();
        logic exp_ic;
        int   loads;
        do_reset();
        loads = 0;
        bus.ic_addr = 32'h400;
        for (int i = 0; i < 10; i++) begin
            bus.ic_req = 1;
            bus.lsb_req = 1; bus.lsb_wr = 0; bus.lsb_width = 3'b010;
            bus.lsb_addr = 32'h1000 + 32'(loads * 4);
            @(negedge clk);
            // Four losses then the fetch wins; the count restarts after the fetch.
            exp_ic = (i == 4) || (i == 9);
            n_cmp++;
            if ({bus.ic_grant, bus.lsb_grant} !== {exp_ic, ~exp_ic}) begin
                n_bad++; $display("FAIL starve_arb%0d: got ic=%b ls=%b want ic=%b", i,
                                  bus.ic_grant, bus.lsb_grant, exp_ic);
            end
            if (exp_ic) bus.ic_req = 0;
            else begin bus.lsb_req = 0; loads++; end
            mc_serve(0, 1, 32'hA000 + 32'(i));
            n_cmp++;
            if ({bus.ic_done, bus.lsb_done} !== {exp_ic, ~exp_ic}) begin
                n_bad++; $display("FAIL starve_done%0d: got %b%b want %b%b", i,
                                  bus.ic_done, bus.lsb_done, exp_ic, ~exp_ic);
            end
        end
        bus.ic_req = 0; bus.lsb_req = 0;
    endtask

    task automatic test_flush_before_accept();
        do_reset();
        // Load under flush in IDLE is not granted.
        clr = 1;
        bus.lsb_req = 1; bus.lsb_wr = 0; bus.lsb_width = 3'b010; bus.lsb_addr = 32'h80;
        @(negedge clk);
        clr = 0;
        n_cmp++;
        if (ctl() !== 9'b0) begin
            n_bad++; $display("FAIL flush_idle_load: got %b want 000000000", ctl());
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.lsb_grant, bus.mc_valid, bus.mc_addr} !== {2'b11, 32'h80}) begin
            n_bad++; $display("FAIL load_grant: got %b%b/%h want 11/00000080",
                              bus.lsb_grant, bus.mc_valid, bus.mc_addr);
        end
        bus.lsb_req = 0;
        clr = 1;
        @(negedge clk);
        clr = 0;
        n_cmp++;
        if ({bus.mc_valid, bus.lsb_done, bus.lsb_grant} !== 3'b000) begin
            n_bad++; $display("FAIL flush_issue: got %b want 000", {bus.mc_valid, bus.lsb_done, bus.lsb_grant});
        end
        bus.lsb_req = 1; bus.lsb_addr = 32'h84;
        @(negedge clk);
        n_cmp++;
        if ({bus.lsb_grant, bus.mc_valid, bus.mc_addr} !== {2'b11, 32'h84}) begin
            n_bad++; $display("FAIL regrant_after_flush: got %b%b/%h want 11/00000084",
                              bus.lsb_grant, bus.mc_valid, bus.mc_addr);
        end
        bus.lsb_req = 0;
        mc_serve(0, 1, 32'h55);
        n_cmp++;
        if ({bus.lsb_done, bus.lsb_rdata} !== {1'b1, 32'h55}) begin
            n_bad++; $display("FAIL load_after_flush_done: got %b/%h want 1/00000055", bus.lsb_done, bus.lsb_rdata);
        end
    endtask

    task automatic test_flush_after_accept();
        do_reset();
        bus.ic_req = 1; bus.ic_addr = 32'h500;
        @(negedge clk);
        bus.ic_req = 0;
        bus.mc_accept = 1;
        @(negedge clk);
        bus.mc_accept = 0;
        clr = 1;
        @(negedge clk);
        clr = 0;
        repeat (2) @(negedge clk);
        bus.mc_done = 1; bus.mc_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mc_done = 0;
        n_cmp++;
        if ({bus.ic_done, bus.ic_data} !== {1'b0, 32'h0}) begin
            n_bad++; $display("FAIL killed_fetch: got %b/%h want 0/00000000", bus.ic_done, bus.ic_data);
        end
        bus.ic_req = 1; bus.ic_addr = 32'h504;
        @(negedge clk);
        n_cmp++;
        if ({bus.ic_grant, bus.mc_addr} !== {1'b1, 32'h504}) begin
            n_bad++; $display("FAIL grant_after_kill: got %b/%h want 1/00000504", bus.ic_grant, bus.mc_addr);
        end
        bus.ic_req = 0;
        mc_serve(0, 1, 32'h1234);
        n_cmp++;
        if ({bus.ic_done, bus.ic_data} !== {1'b1, 32'h1234}) begin
            n_bad++; $display("FAIL fetch_after_kill_done: got %b/%h want 1/00001234", bus.ic_done, bus.ic_data);
        end
        // Flush coinciding with mc_done suppresses a load's done.
        bus.lsb_req = 1; bus.lsb_wr = 0; bus.lsb_addr = 32'h600;
        @(negedge clk);
        bus.lsb_req = 0;
        bus.mc_accept = 1;
        @(negedge clk);
        bus.mc_accept = 0;
        clr = 1; bus.mc_done = 1; bus.mc_rdata = 32'h9;
        @(negedge clk);
        clr = 0; bus.mc_done = 0;
        n_cmp++;
        if ({bus.lsb_done, bus.lsb_rdata} !== {1'b0, 32'h0}) begin
            n_bad++; $display("FAIL flush_with_done: got %b/%h want 0/00000000", bus.lsb_done, bus.lsb_rdata);
        end
        // A store in flight is never killed.
        bus.lsb_req = 1; bus.lsb_wr = 1; bus.lsb_addr = 32'h700; bus.lsb_wdata = 32'h77;
        @(negedge clk);
        bus.lsb_req = 0; bus.lsb_wr = 0;
        bus.mc_accept = 1;
        @(negedge clk);
        bus.mc_accept = 0;
        clr = 1;
        @(negedge clk);
        clr = 0;
        bus.mc_done = 1; bus.mc_rdata = 32'h0;
        @(negedge clk);
        bus.mc_done = 0;
        n_cmp++;
        if (bus.lsb_done !== 1'b1) begin
            n_bad++; $display("FAIL store_not_killed: got %b want 1", bus.lsb_done);
        end
    endtask

    task automatic test_pause_reset();
        do_reset();
        bus.ic_req = 1; bus.ic_addr = 32'h800;
        @(negedge clk);
        bus.ic_req = 0;
        bus.mc_accept = 1;
        @(negedge clk);
        bus.mc_accept = 0;
        rdy = 0; bus.mc_done = 1; bus.mc_rdata = 32'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.ic_done !== 1'b0) begin
                n_bad++; $display("FAIL pause_done%0d: got %b want 0", i, bus.ic_done);
            end
        end
        rdy = 1;
        @(negedge clk);
        bus.mc_done = 0;
        n_cmp++;
        if ({bus.ic_done, bus.ic_data} !== {1'b1, 32'h77}) begin
            n_bad++; $display("FAIL resume_done: got %b/%h want 1/00000077", bus.ic_done, bus.ic_data);
        end
        // Reset while the next fetch is waiting for accept.
        bus.ic_req = 1; bus.ic_addr = 32'h900;
        @(negedge clk);
        bus.ic_req = 0;
        rst_n = 0;
        #1;
        n_cmp++;
        if ({ctl(), bus.mc_addr, bus.ic_data} !== '0) begin
            n_bad++; $display("FAIL reset_mid_issue: got %b/%h/%h want 0", ctl(), bus.mc_addr, bus.ic_data);
        end
        @(negedge clk);
        rst_n = 1;
        bus.mc_accept = 1; bus.mc_done = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.ic_done, bus.mc_valid} !== 2'b00) begin
                n_bad++; $display("FAIL after_reset%0d: got %b want 00", i, {bus.ic_done, bus.mc_valid});
            end
        end
        bus.mc_accept = 0; bus.mc_done = 0;
    endtask

    task automatic test_random();
        logic [2:0]  wcodes [5];
        logic        p_ic, p_ls, ls_wr, win_ls;
        logic [2:0]  ls_w;
        logic [31:0] ic_a, ls_a, ls_d, rd;
        int          losses, acc, dly;
        wcodes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        do_reset();
        p_ic = 0; p_ls = 0; losses = 0;
        ls_wr = 0; ls_w = 0; ic_a = 0; ls_a = 0; ls_d = 0;
        for (int t = 0; t < 60; t++) begin
            if (!p_ic && ($urandom % 3 != 0)) begin
                p_ic = 1; ic_a = $urandom & 32'hFFFF_FFFC;
            end
            if (!p_ls && ($urandom % 4 != 0)) begin
                p_ls = 1; ls_wr = ($urandom % 4 == 0);
                ls_w = wcodes[$urandom_range(4, 0)]; ls_a = $urandom; ls_d = $urandom;
            end
            if (!p_ic && !p_ls) begin
                p_ic = 1; ic_a = $urandom & 32'hFFFF_FFFC;
            end
            bus.ic_req = p_ic; bus.ic_addr = ic_a;
            bus.lsb_req = p_ls; bus.lsb_wr = ls_wr; bus.lsb_width = ls_w;
            bus.lsb_addr = ls_a; bus.lsb_wdata = ls_d;
            // Model: stores first; a fetch that has lost STARVE times in a row beats a load.
            if (p_ls && ls_wr) win_ls = 1;
            else if (p_ls && p_ic && losses >= STARVE) win_ls = 0;
            else win_ls = p_ls;
            if (!win_ls) losses = 0;
            else if (p_ic && losses < STARVE) losses++;
            @(negedge clk);
            n_cmp++;
            if (win_ls) begin
                if ({ctl(), bus.mc_addr, bus.mc_wdata} !== {2'b01, 2'b00, 1'b1, ls_wr, ls_w, ls_a,
                                                           (ls_wr ? ls_d : bus.mc_wdata)}) begin
                    n_bad++; $display("FAIL rnd_ls_grant%0d: got %b/%h/%h want 0100 1 %b %b/%h/%h", t,
                                      ctl(), bus.mc_addr, bus.mc_wdata, ls_wr, ls_w, ls_a, ls_d);
                end
                bus.lsb_req = 0; p_ls = 0;
            end else begin
                if ({ctl(), bus.mc_addr} !== {9'b10_00_1_0_010, ic_a}) begin
                    n_bad++; $display("FAIL rnd_ic_grant%0d: got %b/%h want 100010010/%h", t,
                                      ctl(), bus.mc_addr, ic_a);
                end
                bus.ic_req = 0; p_ic = 0;
            end
            acc = $urandom_range(3, 0);
            dly = $urandom_range(4, 0);
            rd = $urandom;
            for (int k = 0; k < acc; k++) begin
                @(negedge clk);
                n_cmp++;
                if ({bus.mc_valid, bus.ic_done, bus.lsb_done} !== 3'b100) begin
                    n_bad++; $display("FAIL rnd_hold%0d: got %b want 100", t,
                                      {bus.mc_valid, bus.ic_done, bus.lsb_done});
                end
            end
            bus.mc_accept = 1;
            @(negedge clk);
            bus.mc_accept = 0;
            for (int k = 0; k < dly; k++) begin
                n_cmp++;
                if ({bus.mc_valid, bus.ic_done, bus.lsb_done} !== 3'b000) begin
                    n_bad++; $display("FAIL rnd_wait%0d: got %b want 000", t,
                                      {bus.mc_valid, bus.ic_done, bus.lsb_done});
                end
                @(negedge clk);
            end
            bus.mc_done = 1; bus.mc_rdata = rd;
            @(negedge clk);
            bus.mc_done = 0;
            n_cmp++;
            if ({bus.ic_done, bus.lsb_done, (win_ls ? bus.lsb_rdata : bus.ic_data)} !== {~win_ls, win_ls, rd}) begin
                n_bad++; $display("FAIL rnd_done%0d: got %b%b/%h want %b%b/%h", t, bus.ic_done, bus.lsb_done,
                                  (win_ls ? bus.lsb_rdata : bus.ic_data), ~win_ls, win_ls, rd);
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_lone_fetch();
        test_store_priority();
        test_starvation();
        test_flush_before_accept();
        test_flush_after_accept();
        test_pause_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
